lfsr_decrypt_ctrl: RTL and testbench

Sequencing controller for the Lab 5 decryption path. It reads an encrypted 64-byte message from data memory [64:127] and recovers the LFSR tap pattern and starting state from the known `_` (8'h5f) preamble. It then decrypts the message and writes it, with leading underscores stripped, to data memory [0:63]. It sits between the top level's `init`/`done` handshake and the `dm1` memory ports, and owns the 6-bit LFSR used for decryption.

---
 rtl/lfsr_decrypt_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lfsr_decrypt_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl
// Sequencer for the LFSR decryption path. Reads a 64-byte cipher text from
// memory [MSG_BASE +: 64], recovers the LFSR start state and tap pattern from
// the known 8'h5f preamble, then decrypts the message and writes it to
// memory [0:63] with the leading underscores removed.
//
// Ports
//   clk        in   system clock, rising edge
//   init       in   asynchronous active-high reset; falling edge starts a run
//   raddr      out  memory read address (memory returns data one clock later)
//   rdata      in   memory read data
//   wr_en      out  memory write enable
//   waddr      out  memory write address (0..63)
//   wdata      out  memory write data
//   done       out  run complete, held until init rises
//   found      out  a tap pattern matched the preamble
//   ptrn_sel   out  index of the matched tap pattern
//   lfsr_start out  recovered LFSR start state
//   msg_len    out  number of bytes written
module lfsr_decrypt_ctrl #(
  parameter int NUM_PTRN = 6,
  parameter int CHK_LEN  = 6,
  parameter int MSG_BASE = 64
) (
  input  logic       clk,
  input  logic       init,
  output logic [7:0] raddr,
  input  logic [7:0] rdata,
  output logic       wr_en,
  output logic [7:0] waddr,
  output logic [7:0] wdata,
  output logic       done,
  output logic       found,
  output logic [2:0] ptrn_sel,
  output logic [5:0] lfsr_start,
  output logic [6:0] msg_len
);

  localparam logic [7:0] BASE_ADDR = 8'(MSG_BASE);
  localparam logic [6:0] CHK_CNT   = 7'(CHK_LEN);
  localparam logic [6:0] TRY_LAST  = 7'(CHK_LEN + 1);
  localparam logic [6:0] DEC_LAST  = 7'd64;
  localparam logic [6:0] LEN_MAX   = 7'd64;
  localparam logic [2:0] LAST_PTRN = 3'(NUM_PTRN - 1);
  localparam logic [5:0] PRE_BITS  = 6'h1f;
  localparam logic [7:0] PRE_BYTE  = 8'h5f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_TRY,
    S_DECODE,
    S_FAIL,
    S_DONE
  } state_t;

  function automatic logic [5:0] ptrn_of(input logic [2:0] idx);
    logic [5:0] taps;
    case (idx)
      3'd0:    taps = 6'h21;
      3'd1:    taps = 6'h2D;
      3'd2:    taps = 6'h30;
      3'd3:    taps = 6'h33;
      3'd4:    taps = 6'h36;
      3'd5:    taps = 6'h39;
      default: taps = 6'h21;
    endcase
    return taps;
  endfunction

  state_t     state_q;
  logic [6:0] cnt_q;        // cycle index within a trial or the decode sweep
  logic [2:0] p_q;          // pattern under trial, then the chosen pattern
  logic [5:0] s0_q;
  logic [5:0] lfsr_q;
  logic       mm_q;         // sticky preamble mismatch for the current trial
  logic       lead_q;       // still stripping leading underscores
  logic [7:0] raddr_q;
  logic       done_q;
  logic       found_q;
  logic [2:0] ptrn_sel_q;
  logic [5:0] lfsr_start_q;
  logic [6:0] msg_len_q;

  logic [5:0] ptrn;
  logic [5:0] lfsr_step;
  logic [5:0] s0_d;
  logic       chk_bad;
  logic       dec_data;
  logic       wr_en_d;
  logic [7:0] plain;

  always_comb begin
    ptrn      = ptrn_of(p_q);
    lfsr_step = {lfsr_q[4:0], ^(lfsr_q & ptrn)};
    // Cipher byte 0 arrives during the very first trial cycle; later trials
    // reuse the captured copy.
    s0_d      = (p_q == 3'd0 && cnt_q == 7'd0) ? (rdata[5:0] ^ PRE_BITS) : s0_q;
    chk_bad   = (rdata[5:0] ^ lfsr_q) != PRE_BITS;
    plain     = rdata ^ {2'b00, lfsr_q};
    // cnt 1..64 of the sweep carries the data of cipher bytes 0..63
    dec_data  = (state_q == S_DECODE) && (cnt_q != 7'd0);
    wr_en_d   = dec_data && (!lead_q || plain != PRE_BYTE);
  end

  // The write port is decoded straight from the returning read data so that a
  // write lands exactly one cycle behind its read address; since it is gated
  // by the state register, init clears it in the same cycle.
  assign wr_en      = wr_en_d;
  assign waddr      = {1'b0, msg_len_q};
  assign wdata      = wr_en_d ? plain : 8'h00;
  assign raddr      = raddr_q;
  assign done       = done_q;
  assign found      = found_q;
  assign ptrn_sel   = ptrn_sel_q;
  assign lfsr_start = lfsr_start_q;
  assign msg_len    = msg_len_q;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q      <= S_IDLE;
      cnt_q        <= 7'd0;
      p_q          <= 3'd0;
      s0_q         <= 6'd0;
      lfsr_q       <= 6'd0;
      mm_q         <= 1'b0;
      lead_q       <= 1'b0;
      raddr_q      <= 8'd0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      ptrn_sel_q   <= 3'd0;
      lfsr_start_q <= 6'd0;
      msg_len_q    <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_SEED;
          raddr_q <= BASE_ADDR;
        end

        S_SEED: begin
          state_q <= S_TRY;
          cnt_q   <= 7'd0;
          p_q     <= 3'd0;
        end

        // Trial timeline: cnt 0 loads s0, cnt 1 steps to s1, cnt 2..CHK_LEN+1
        // each see cipher byte i = cnt-1 alongside s_i.
        S_TRY: begin
          if (cnt_q == 7'd0) begin
            s0_q   <= s0_d;
            lfsr_q <= s0_d;
            mm_q   <= 1'b0;
          end else begin
            lfsr_q <= lfsr_step;
          end
          if (cnt_q < CHK_CNT) begin
            raddr_q <= BASE_ADDR + 8'd1 + {1'b0, cnt_q};
          end
          if (cnt_q >= 7'd2 && cnt_q < TRY_LAST) begin
            mm_q <= mm_q | chk_bad;
          end
          if (cnt_q == TRY_LAST) begin
            cnt_q <= 7'd0;
            if (!(mm_q | chk_bad)) begin
              state_q      <= S_DECODE;
              found_q      <= 1'b1;
              ptrn_sel_q   <= p_q;
              lfsr_start_q <= s0_q;
              lfsr_q       <= s0_q;
              raddr_q      <= BASE_ADDR;
              lead_q       <= 1'b1;
              msg_len_q    <= 7'd0;
            end else if (p_q == LAST_PTRN) begin
              state_q <= S_FAIL;
            end else begin
              p_q <= p_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end

        // Sweep: cnt c issues read c (c = 0..63); its data returns at cnt c+1.
        S_DECODE: begin
          if (cnt_q < 7'd63) begin
            raddr_q <= raddr_q + 8'd1;
          end
          if (dec_data) begin
            lfsr_q <= lfsr_step;
            if (plain != PRE_BYTE) begin
              lead_q <= 1'b0;
            end
          end
          if (wr_en_d && msg_len_q != LEN_MAX) begin
            msg_len_q <= msg_len_q + 7'd1;
          end
          if (cnt_q == DEC_LAST) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end

        S_FAIL: begin
          found_q      <= 1'b0;
          ptrn_sel_q   <= 3'd0;
          lfsr_start_q <= 6'd0;
          msg_len_q    <= 7'd0;
          state_q      <= S_DONE;
        end

        S_DONE: begin
          done_q <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
module tb_lfsr_decrypt_ctrl;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [7:0] raddr;
  logic [7:0] rdata;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       done;
  logic       found;
  logic [2:0] ptrn_sel;
  logic [5:0] lfsr_start;
  logic [6:0] msg_len;

  lfsr_decrypt_ctrl dut (
    .clk        (clk),
    .init       (init),
    .raddr      (raddr),
    .rdata      (rdata),
    .wr_en      (wr_en),
    .waddr      (waddr),
    .wdata      (wdata),
    .done       (done),
    .found      (found),
    .ptrn_sel   (ptrn_sel),
    .lfsr_start (lfsr_start),
    .msg_len    (msg_len)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] PT [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] cmem [64];
  logic [7:0] omem [64];
  logic       clr = 1'b0;
  wr_t        exp_q [$];
  wr_t        mon_e;
  logic [7:0] pl [64];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc;

  // expected results produced by the model
  bit         m_found;
  logic [2:0] m_sel;
  logic [5:0] m_start;
  int         m_len;

  // memory: synchronous read of the cipher region, write port to [0:63]
  always @(posedge clk) begin
    if (raddr >= 8'd64 && raddr < 8'd128) rdata <= cmem[raddr[5:0]];
    else rdata <= 8'h00;
    if (clr) begin
      for (int i = 0; i < 64; i++) omem[i] <= 8'h00;
    end else if (wr_en && waddr < 8'd64) begin
      omem[waddr[5:0]] <= wdata;
    end
  end

  always @(posedge clk or posedge init) begin
    if (init) cyc <= -1;
    else cyc <= cyc + 1;
  end

  // scoreboard: every write is popped against the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_write: got addr=%0d data=%02h, required no write", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (waddr !== mon_e.a || wdata !== mon_e.d) begin
          n_bad++;
          $display("FAIL sb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   waddr, wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  function automatic logic [5:0] stepf(input logic [5:0] s, input logic [5:0] p);
    return {s[4:0], ^(s & p)};
  endfunction

  // encrypt a preamble + message + padding with pattern pidx from seed
  task automatic load_cipher(input int pidx, input logic [5:0] seed, input int pre,
                             input string m, input logic [7:0] pad, input bit rnd);
    logic [5:0] s;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      if (i < pre) pl[i] = 8'h5f;
      else if (i < pre + m.len()) pl[i] = m[i - pre];
      else if (rnd) pl[i] = 8'($urandom_range(0, 255));
      else pl[i] = pad;
      cmem[i] = pl[i] ^ {2'b00, s};
      s = stepf(s, PT[pidx]);
    end
  endtask

  // model from the cipher text alone; fills the expected-write queue
  task automatic build_expect();
    logic [5:0] s0, s;
    logic [7:0] pt;
    bit ok, lead;
    s0 = cmem[0][5:0] ^ 6'h1f;
    m_found = 0; m_sel = 0; m_start = 0; m_len = 0;
    exp_q.delete();
    for (int p = 0; p < 6 && !m_found; p++) begin
      s = s0; ok = 1;
      for (int i = 1; i <= 6; i++) begin
        s = stepf(s, PT[p]);
        if ((cmem[i][5:0] ^ s) != 6'h1f) ok = 0;
      end
      if (ok) begin m_found = 1; m_sel = 3'(p); end
    end
    if (m_found) begin
      m_start = s0; s = s0; lead = 1;
      for (int j = 0; j < 64; j++) begin
        pt = cmem[j] ^ {2'b00, s};
        if (!(lead && pt == 8'h5f)) begin
          lead = 0;
          exp_q.push_back('{8'(m_len), pt});
          m_len++;
        end
        s = stepf(s, PT[m_sel]);
      end
    end
  endtask

  task automatic prep();
    init = 1'b1;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_run(output int dcyc, output bit tmo);
    dcyc = -1; tmo = 0;
    @(negedge clk); init = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
    end
    if (dcyc < 0) tmo = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({raddr, waddr, wdata} !== 24'h0) begin n_bad++;
      $display("FAIL reset_addr: got %06h, required 000000", {raddr, waddr, wdata}); end
    n_cmp++; if ({wr_en, done, found, ptrn_sel} !== 6'h0) begin n_bad++;
      $display("FAIL reset_flags: got %02h, required 00", {wr_en, done, found, ptrn_sel}); end
    n_cmp++; if ({lfsr_start, msg_len} !== 13'h0) begin n_bad++;
      $display("FAIL reset_status: got %04h, required 0000", {lfsr_start, msg_len}); end
  endtask

  task automatic test_watson();
    string m = "Mr_Watson_come_here";
    int dc; bit tmo;
    prep();
    load_cipher(2, 6'h01, 7, m, 8'h5f, 0);
    build_expect();
    do_run(dc, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL watson_timeout: done never rose, required done"); end
    n_cmp++; if (dc !== 91) begin n_bad++; $display("FAIL watson_done_cyc: got %0d, required 91", dc); end
    n_cmp++; if ({found, ptrn_sel} !== {1'b1, 3'd2}) begin n_bad++;
      $display("FAIL watson_sel: got found=%0b sel=%0d, required found=1 sel=2", found, ptrn_sel); end
    n_cmp++; if (lfsr_start !== 6'h01) begin n_bad++;
      $display("FAIL watson_start: got %02h, required 01", lfsr_start); end
    n_cmp++; if (msg_len !== 7'd57) begin n_bad++;
      $display("FAIL watson_len: got %0d, required 57", msg_len); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++;
      $display("FAIL watson_sb_left: got %0d pending, required 0", exp_q.size()); end
    for (int i = 0; i < m.len(); i++) begin
      n_cmp++; if (omem[i] !== m[i]) begin n_bad++;
        $display("FAIL watson_mem[%0d]: got %02h, required %02h", i, omem[i], m[i]); end
    end
    $display("watson: sel=%0d start=%02h len=%0d done_cyc=%0d", ptrn_sel, lfsr_start, msg_len, dc);
  endtask

  task automatic test_strip_lead();
    int dc; bit tmo;
    prep();
    load_cipher(5, 6'h3f, 12, "___@@@@@", 8'h5f, 0);
    build_expect();
    do_run(dc, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL strip_timeout: done never rose, required done"); end
    n_cmp++; if ({found, ptrn_sel, lfsr_start} !== {1'b1, 3'd5, 6'h3f}) begin n_bad++;
      $display("FAIL strip_sel: got found=%0b sel=%0d start=%02h, required 1/5/3f", found, ptrn_sel, lfsr_start); end
    n_cmp++; if (omem[0] !== 8'h40) begin n_bad++;
      $display("FAIL strip_mem0: got %02h, required 40", omem[0]); end
    n_cmp++; if (msg_len !== 7'(m_len) || exp_q.size() != 0) begin n_bad++;
      $display("FAIL strip_len: got %0d (pending %0d), required %0d", msg_len, exp_q.size(), m_len); end
    $display("strip_lead: sel=%0d len=%0d mem0=%02h", ptrn_sel, msg_len, omem[0]);
  endtask

  task automatic test_no_match();
    int dc; bit tmo; int nz;
    prep();
    for (int i = 0; i < 64; i++) cmem[i] = 8'h00;
    build_expect();
    do_run(dc, tmo);
    nz = 0;
    for (int i = 0; i < 64; i++) if (omem[i] !== 8'h00) nz++;
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL nomatch_timeout: done never rose, required done"); end
    n_cmp++; if (dc !== 51) begin n_bad++; $display("FAIL nomatch_done_cyc: got %0d, required 51", dc); end
    n_cmp++; if ({found, ptrn_sel, lfsr_start, msg_len} !== 17'h0) begin n_bad++;
      $display("FAIL nomatch_status: got found=%0b sel=%0d start=%02h len=%0d, required all 0",
               found, ptrn_sel, lfsr_start, msg_len); end
    n_cmp++; if (nz != 0) begin n_bad++; $display("FAIL nomatch_mem: got %0d written bytes, required 0", nz); end
    $display("no_match: found=%0b len=%0d done_cyc=%0d", found, msg_len, dc);
  endtask

  task automatic test_inner_underscore();
    int dc; bit tmo;
    prep();
    load_cipher(0, 6'h2a, 8, "A_B", 8'h2e, 0);
    build_expect();
    do_run(dc, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL inner_timeout: done never rose, required done"); end
    n_cmp++; if ({omem[0], omem[1], omem[2]} !== 24'h415f42) begin n_bad++;
      $display("FAIL inner_mem: got %02h %02h %02h, required 41 5f 42", omem[0], omem[1], omem[2]); end
    n_cmp++; if ({found, ptrn_sel, msg_len} !== {1'b1, 3'd0, 7'd56}) begin n_bad++;
      $display("FAIL inner_status: got found=%0b sel=%0d len=%0d, required 1/0/56", found, ptrn_sel, msg_len); end
    $display("inner_underscore: mem0..2=%02h %02h %02h len=%0d", omem[0], omem[1], omem[2], msg_len);
  endtask

  task automatic test_interrupt();
    string m = "Mr_Watson_come_here";
    int dc; bit tmo; bit hit;
    prep();
    load_cipher(2, 6'h01, 7, m, 8'h5f, 0);
    build_expect();
    @(negedge clk); init = 1'b0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc == 46) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL intr_reach: cycle 46 not reached, required reached"); end
    n_cmp++; if ({wr_en, waddr} !== {1'b1, 8'd13}) begin n_bad++;
      $display("FAIL intr_pre: got wr_en=%0b waddr=%0d, required 1/13", wr_en, waddr); end
    #2 init = 1'b1;
    #1;
    n_cmp++; if ({wr_en, done, raddr, msg_len} !== 17'h0) begin n_bad++;
      $display("FAIL intr_clear: got wr_en=%0b done=%0b raddr=%0d len=%0d, required all 0",
               wr_en, done, raddr, msg_len); end
    build_expect();
    do_run(dc, tmo);
    n_cmp++; if (tmo || dc !== 91) begin n_bad++;
      $display("FAIL intr_rerun_cyc: got %0d (timeout=%0b), required 91", dc, tmo); end
    n_cmp++; if ({found, ptrn_sel, lfsr_start, msg_len} !== {1'b1, 3'd2, 6'h01, 7'd57}) begin n_bad++;
      $display("FAIL intr_rerun_status: got %0b/%0d/%02h/%0d, required 1/2/01/57",
               found, ptrn_sel, lfsr_start, msg_len); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++;
      $display("FAIL intr_sb_left: got %0d pending, required 0", exp_q.size()); end
    $display("interrupt: rerun sel=%0d len=%0d done_cyc=%0d", ptrn_sel, msg_len, dc);
  endtask

  task automatic test_sweep();
    logic [5:0] seeds [3] = '{6'h01, 6'h2a, 6'h3f};
    int dc; bit tmo; int req_dc;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 3; k++) begin
        prep();
        load_cipher(p, seeds[k], 7, "", 8'h00, 1);
        build_expect();
        req_dc = 1 + 8 * (int'(m_sel) + 1) + 66;
        do_run(dc, tmo);
        n_cmp++; if (tmo || dc !== req_dc) begin n_bad++;
          $display("FAIL sweep_done_cyc p=%0d seed=%02h: got %0d, required %0d", p, seeds[k], dc, req_dc); end
        n_cmp++; if (found !== 1'b1 || ptrn_sel !== m_sel || int'(ptrn_sel) > p) begin n_bad++;
          $display("FAIL sweep_sel p=%0d seed=%02h: got found=%0b sel=%0d, required 1/%0d",
                   p, seeds[k], found, ptrn_sel, m_sel); end
        n_cmp++; if (lfsr_start !== seeds[k] || msg_len !== 7'(m_len) || exp_q.size() != 0) begin n_bad++;
          $display("FAIL sweep_status p=%0d seed=%02h: got start=%02h len=%0d pending=%0d, required %02h/%0d/0",
                   p, seeds[k], lfsr_start, msg_len, exp_q.size(), seeds[k], m_len); end
        $display("sweep: p=%0d seed=%02h sel=%0d len=%0d", p, seeds[k], ptrn_sel, msg_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_watson();
    test_strip_lead();
    test_no_match();
    test_inner_underscore();
    test_interrupt();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
